spi_bus_arbiter: RTL and testbench

Shares one SPI byte transmitter (the command/data engine pair, split downstream on DC) between N_REQ drawing clients, such as init sequencer, square drawer and text drawer. It grants whole transactions round-robin and sequences bytes through a valid/ready handshake and the transmitter's we/done handshake. A watchdog frees the bus if the transmitter never completes.

---
 rtl/spi_bus_pkg.sv | 17 +
 rtl/spi_arb_rr_pick.sv | 31 +++
 rtl/spi_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bus_pkg.sv
// Shared definitions for the SPI bus arbiter: state encoding, default sizing
// and the DC flag meanings used by the downstream command/data engines.
package spi_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SEND  = 2'd2
    } arb_state_e;

    localparam int DEF_N_REQ      = 3;
    localparam int DEF_TX_TIMEOUT = 4096;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/spi_arb_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from ptr_i+1 with wrap-around, so the last winner has lowest priority.
module spi_arb_rr_pick #(
    parameter int N_REQ = 3,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [IW-1:0]    win_o,
    output logic             any_o
);

    // Scan offsets 1..N_REQ from the pointer and keep the first hit.
    always_comb begin
        int j;
        win_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!any_o && req_i[j]) begin
                any_o = 1'b1;
                win_o = IW'(j);
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI byte transmitter between N_REQ clients. Whole transactions
// are granted round-robin; bytes move through a valid/ready handshake on the
// client side and a we/done handshake on the transmitter side. A per-byte
// watchdog frees the bus if the transmitter never reports done.
module spi_bus_arbiter
    import spi_bus_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int TX_TIMEOUT = DEF_TX_TIMEOUT,
    parameter int CNT_W      = 12
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ-1:0]   i_valid,
    input  logic [8*N_REQ-1:0] i_byte,
    input  logic [N_REQ-1:0]   i_dc,
    input  logic [N_REQ-1:0]   i_last,
    output logic [N_REQ-1:0]   o_ready,
    output logic [N_REQ-1:0]   o_grant,
    output logic [7:0]         o_tx_byte,
    output logic               o_tx_dc,
    output logic               o_tx_we,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_err
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // The abort decision is registered, so it is taken one count early; the
    // error pulse then lands on the cycle the watchdog reads TX_TIMEOUT-1.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TX_TIMEOUT - 2);

    arb_state_e         state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]   wdog_q, wdog_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               tx_dc_q, tx_dc_d;
    logic               last_q, last_d;
    logic               we_q, we_d;
    logic [N_REQ-1:0]   ready_q, ready_d;
    logic               err_q, err_d;

    logic [IW-1:0]      pick_win;
    logic               pick_any;

    logic               g_req;
    logic               g_valid;
    logic [7:0]         g_byte;
    logic               g_dc;
    logic               g_last;

    spi_arb_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req_i (i_req),
        .ptr_i (ptr_q),
        .win_o (pick_win),
        .any_o (pick_any)
    );

    // Route the granted requester's request, valid, byte, DC and last flags.
    always_comb begin
        g_req   = 1'b0;
        g_valid = 1'b0;
        g_byte  = 8'h00;
        g_dc    = 1'b0;
        g_last  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gidx_q == IW'(k)) begin
                g_req   = i_req[k];
                g_valid = i_valid[k];
                g_byte  = i_byte[8*k +: 8];
                g_dc    = i_dc[k];
                g_last  = i_last[k];
            end
        end
    end

    // Next-state and registered-output logic of the arbitration FSM.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        wdog_d    = wdog_q;
        tx_byte_d = tx_byte_q;
        tx_dc_d   = tx_dc_q;
        last_d    = last_q;
        we_d      = 1'b0;
        ready_d   = '0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    gidx_d  = pick_win;
                    for (int k = 0; k < N_REQ; k++) begin
                        grant_d[k] = (pick_win == IW'(k));
                    end
                end
            end
            ST_GRANT: begin
                if (!g_req && !g_valid) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = gidx_q;
                end else if (g_valid) begin
                    tx_byte_d = g_byte;
                    tx_dc_d   = g_dc;
                    last_d    = g_last;
                    we_d      = 1'b1;
                    ready_d   = grant_q;
                    wdog_d    = '0;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                wdog_d = wdog_q + CNT_W'(1);
                if (i_tx_done) begin
                    if (last_q || !g_req) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        ptr_d   = gidx_q;
                    end else begin
                        state_d = ST_GRANT;
                    end
                end else if (wdog_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = gidx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any grant immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= IW'(N_REQ - 1);
            wdog_q    <= '0;
            tx_byte_q <= 8'h00;
            tx_dc_q   <= DC_CMD;
            last_q    <= 1'b0;
            we_q      <= 1'b0;
            ready_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            wdog_q    <= wdog_d;
            tx_byte_q <= tx_byte_d;
            tx_dc_q   <= tx_dc_d;
            last_q    <= last_d;
            we_q      <= we_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    assign o_grant   = grant_q;
    assign o_ready   = ready_q;
    assign o_tx_byte = tx_byte_q;
    assign o_tx_dc   = tx_dc_q;
    assign o_tx_we   = we_q;
    assign o_err     = err_q;
    assign o_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: a cycle table for round-robin order
// plus hand sequences for transfers, hold-off, timeout and reset.
module tb_spi_bus_arbiter;
    import spi_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0, valid = '0, dc = '0, last = '0;
    logic [23:0] bytes = '0;
    logic        done = 1'b0;

    logic [2:0]  a_ready, a_grant, b_ready, b_grant;
    logic [7:0]  a_tx_byte, b_tx_byte;
    logic        a_tx_dc, a_we, a_busy, a_err;
    logic        b_tx_dc, b_we, b_busy, b_err;

    int total = 0;
    int bad = 0;
    int we_cnt = 0, ready_cnt = 0, a_err_cnt = 0;

    always #5 clk = ~clk;

    spi_bus_arbiter #(.N_REQ(3), .TX_TIMEOUT(4096), .CNT_W(12)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_valid(valid),
        .i_byte(bytes), .i_dc(dc), .i_last(last), .o_ready(a_ready),
        .o_grant(a_grant), .o_tx_byte(a_tx_byte), .o_tx_dc(a_tx_dc),
        .o_tx_we(a_we), .i_tx_done(done), .o_busy(a_busy), .o_err(a_err)
    );

    spi_bus_arbiter #(.N_REQ(3), .TX_TIMEOUT(16), .CNT_W(5)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_valid(valid),
        .i_byte(bytes), .i_dc(dc), .i_last(last), .o_ready(b_ready),
        .o_grant(b_grant), .o_tx_byte(b_tx_byte), .o_tx_dc(b_tx_dc),
        .o_tx_we(b_we), .i_tx_done(done), .o_busy(b_busy), .o_err(b_err)
    );

    always @(negedge clk) begin
        if (a_we) we_cnt <= we_cnt + 1;
        if (a_ready != 3'b000) ready_cnt <= ready_cnt + 1;
        if (a_err) a_err_cnt <= a_err_cnt + 1;
    end

    typedef struct {
        logic [2:0] req;
        logic [2:0] valid;
        logic       done;
        logic [2:0] grant;
        logic [2:0] ready;
        logic       we;
        logic [7:0] txb;
        logic       txdc;
        logic       busy;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        req = '0; valid = '0; dc = '0; last = '0; bytes = '0; done = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One byte from requester k: strobe checked one cycle after valid, then
    // a done pulse issued dly cycles later.
    task automatic send(input int k, input logic [7:0] b, input logic d,
                        input logic l, input int dly, input string nm);
        valid[k] = 1'b1; bytes[8*k +: 8] = b; dc[k] = d; last[k] = l;
        @(posedge clk); #1;
        chk($sformatf("%s_we", nm), a_we, 1);
        chk($sformatf("%s_ready", nm), a_ready, 32'(1 << k));
        chk($sformatf("%s_byte", nm), a_tx_byte, b);
        chk($sformatf("%s_dc", nm), a_tx_dc, d);
        valid[k] = 1'b0; last[k] = 1'b0;
        repeat (dly - 1) @(posedge clk);
        #1 done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL tb_timeout: simulation did not end, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int wbase, rbase, errat;
        logic [2:0] gsnap, gnext;
        logic [17:0] act, exp;

        //               req     valid   dn    grant   ready   we    txb    dc    busy
        tbl[0]  = '{3'b111, 3'b111, 1'b0, 3'b001, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[1]  = '{3'b111, 3'b111, 1'b0, 3'b001, 3'b001, 1'b1, 8'h10, 1'b0, 1'b1};
        tbl[2]  = '{3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 8'h10, 1'b0, 1'b0};
        tbl[3]  = '{3'b111, 3'b111, 1'b0, 3'b010, 3'b000, 1'b0, 8'h10, 1'b0, 1'b1};
        tbl[4]  = '{3'b111, 3'b111, 1'b0, 3'b010, 3'b010, 1'b1, 8'h11, 1'b1, 1'b1};
        tbl[5]  = '{3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 8'h11, 1'b1, 1'b0};
        tbl[6]  = '{3'b111, 3'b111, 1'b0, 3'b100, 3'b000, 1'b0, 8'h11, 1'b1, 1'b1};
        tbl[7]  = '{3'b111, 3'b111, 1'b0, 3'b100, 3'b100, 1'b1, 8'h12, 1'b0, 1'b1};
        tbl[8]  = '{3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 8'h12, 1'b0, 1'b0};
        tbl[9]  = '{3'b011, 3'b011, 1'b0, 3'b001, 3'b000, 1'b0, 8'h12, 1'b0, 1'b1};
        tbl[10] = '{3'b011, 3'b011, 1'b0, 3'b001, 3'b001, 1'b1, 8'h10, 1'b0, 1'b1};
        tbl[11] = '{3'b011, 3'b011, 1'b1, 3'b000, 3'b000, 1'b0, 8'h10, 1'b0, 1'b0};
        tbl[12] = '{3'b011, 3'b011, 1'b0, 3'b010, 3'b000, 1'b0, 8'h10, 1'b0, 1'b1};
        tbl[13] = '{3'b011, 3'b011, 1'b0, 3'b010, 3'b010, 1'b1, 8'h11, 1'b1, 1'b1};
        tbl[14] = '{3'b011, 3'b011, 1'b1, 3'b000, 3'b000, 1'b0, 8'h11, 1'b1, 1'b0};

        // Reset state
        rst_n = 1'b0;
        #12;
        chk("reset_out", {a_grant, a_ready, a_we, a_tx_byte, a_tx_dc, a_busy, a_err}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Done while idle is ignored
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        chk("idle_done_busy", {a_busy, a_grant}, 0);

        // Round-robin table: 1-byte last transactions
        bytes = {8'h12, 8'h11, 8'h10};
        dc    = 3'b010;
        last  = 3'b111;
        for (int i = 0; i < 15; i++) begin
            req   = tbl[i].req;
            valid = tbl[i].valid;
            done  = tbl[i].done;
            @(posedge clk); #1;
            act = {a_grant, a_ready, a_we, a_tx_byte, a_tx_dc, a_busy, a_err};
            exp = {tbl[i].grant, tbl[i].ready, tbl[i].we, tbl[i].txb, tbl[i].txdc, tbl[i].busy, 1'b0};
            chk($sformatf("vec%0d", i), act, exp);
        end

        // Single requester, three-byte transaction
        do_reset();
        req = 3'b001;
        @(posedge clk); #1;
        chk("a_grant", a_grant, 3'b001);
        wbase = we_cnt; rbase = ready_cnt;
        send(0, 8'h2A, DC_CMD, 1'b0, 20, "a0");
        chk("a0_hold", a_grant, 3'b001);
        send(0, 8'h00, DC_DATA, 1'b0, 20, "a1");
        send(0, 8'h46, DC_DATA, 1'b1, 20, "a2");
        chk("a_drop", {a_grant, a_busy}, 0);
        chk("a_we_count", we_cnt - wbase, 3);
        chk("a_ready_count", ready_cnt - rbase, 3);
        req = 3'b000;

        // Requester 1 keeps the bus while requester 0 waits
        do_reset();
        req = 3'b010;
        @(posedge clk); #1;
        chk("b_grant", a_grant, 3'b010);
        req = 3'b011;
        valid[0] = 1'b1; bytes[7:0] = 8'h55;
        send(1, 8'hA1, DC_CMD, 1'b0, 3, "b0");
        chk("b_hold", a_grant, 3'b010);
        send(1, 8'hA2, DC_DATA, 1'b1, 3, "b1");
        chk("b_drop", a_grant, 3'b000);
        @(posedge clk); #1;
        chk("b_next", a_grant, 3'b001);

        // Request withdrawn during SEND
        do_reset();
        req = 3'b001;
        @(posedge clk); #1;
        rbase = ready_cnt;
        valid[0] = 1'b1; bytes[7:0] = 8'h77;
        @(posedge clk); #1;
        chk("c_we", a_we, 1);
        valid[0] = 1'b0; req = 3'b000;
        repeat (3) @(posedge clk);
        #1 done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        chk("c_idle", {a_grant, a_busy}, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("c_ready_count", ready_cnt - rbase, 1);

        // Watchdog abort on the short-timeout instance
        do_reset();
        req = 3'b101;
        @(posedge clk); #1;
        chk("d_grant", b_grant, 3'b001);
        valid[0] = 1'b1; bytes[7:0] = 8'h99; last[0] = 1'b1;
        @(posedge clk); #1;
        chk("d_we", b_we, 1);
        valid[0] = 1'b0; last[0] = 1'b0;
        errat = -1; gsnap = 3'b111; gnext = 3'b000;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (b_err && errat < 0) errat = n;
            if (n == 15) gsnap = b_grant;
            if (n == 16) gnext = b_grant;
        end
        chk("d_err_cycle", errat, 15);
        chk("d_drop", gsnap, 3'b000);
        chk("d_next", gnext, 3'b100);
        chk("d_long_busy", a_busy, 1);

        // Done on the last watchdog cycle wins over the abort
        do_reset();
        req = 3'b001;
        @(posedge clk); #1;
        valid[0] = 1'b1; last[0] = 1'b1;
        @(posedge clk); #1;
        valid[0] = 1'b0; last[0] = 1'b0;
        repeat (14) @(posedge clk);
        #1 done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        chk("e_err", b_err, 0);
        chk("e_drop", {b_grant, b_busy}, 0);

        // Asynchronous reset during SEND
        do_reset();
        req = 3'b001;
        @(posedge clk); #1;
        valid[0] = 1'b1;
        @(posedge clk); #1;
        chk("f_we", a_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("f_async", {a_grant, a_we, a_ready, a_busy}, 0);
        valid[0] = 1'b0; req = 3'b111;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("f_prio", a_grant, 3'b001);
        req = 3'b000;

        chk("a_no_err", a_err_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
